// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: decode-side inputs, forwarding sources and EX-side outputs of the ID/EX operand stage
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic              stall;
  logic              flush;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [15:0]       imm16;
  logic              ext_zero;
  logic              alu_src_in;
  logic              reg_write_in;
  logic              mem_read_in;
  logic [REG_AW-1:0] rd_in;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              load_use_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_src_a;
  logic [DATA_W-1:0] ex_src_b;
  logic [DATA_W-1:0] ex_constante;
  logic              ex_alu_src;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  modport master (
    output id_valid, stall, flush, rs_addr, rt_addr, rs_data, rt_data, imm16, ext_zero,
           alu_src_in, reg_write_in, mem_read_in, rd_in, exmem_reg_write, exmem_rd,
           exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    input  load_use_stall, ex_valid, ex_src_a, ex_src_b, ex_constante, ex_alu_src,
           ex_reg_write, ex_mem_read, ex_rd
  );
  modport slave (
    input  id_valid, stall, flush, rs_addr, rt_addr, rs_data, rt_data, imm16, ext_zero,
           alu_src_in, reg_write_in, mem_read_in, rd_in, exmem_reg_write, exmem_rd,
           exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    output load_use_stall, ex_valid, ex_src_a, ex_src_b, ex_constante, ex_alu_src,
           ex_reg_write, ex_mem_read, ex_rd
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with immediate extension, operand forwarding and load-use bubble
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic rst_n,
  id_ex_operand_stage_if.slave bus
);
  logic              valid_q;
  logic [DATA_W-1:0] src_a_q;
  logic [DATA_W-1:0] src_b_q;
  logic [DATA_W-1:0] const_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic [REG_AW-1:0] rd_q;
  logic              a_ex, a_wb, b_ex, b_wb, lus, bubble;
  logic [DATA_W-1:0] fwd_a, fwd_b, constante;
  // forwarding select and immediate extension; register 0 never matches
  always_comb begin
    a_ex = bus.exmem_reg_write && bus.exmem_rd == bus.rs_addr && bus.rs_addr != '0;
    a_wb = bus.memwb_reg_write && bus.memwb_rd == bus.rs_addr && bus.rs_addr != '0;
    b_ex = bus.exmem_reg_write && bus.exmem_rd == bus.rt_addr && bus.rt_addr != '0;
    b_wb = bus.memwb_reg_write && bus.memwb_rd == bus.rt_addr && bus.rt_addr != '0;
    fwd_a = a_ex ? bus.exmem_result : a_wb ? bus.memwb_result : bus.rs_data;
    fwd_b = b_ex ? bus.exmem_result : b_wb ? bus.memwb_result : bus.rt_data;
    constante = bus.ext_zero ? {{(DATA_W-16){1'b0}}, bus.imm16}
                             : {{(DATA_W-16){bus.imm16[15]}}, bus.imm16};
    lus = bus.id_valid && valid_q && mem_read_q && rd_q != '0 &&
          (rd_q == bus.rs_addr || rd_q == bus.rt_addr);
    bubble = !rst_n || bus.flush || (!bus.stall && lus);
  end
  // pipeline register: clear on reset/flush/hazard, hold on stall, else capture
  always_ff @(posedge clk) begin
    if (bubble) begin
      valid_q     <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      const_q     <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rd_q        <= '0;
    end else if (!bus.stall) begin
      valid_q     <= bus.id_valid;
      src_a_q     <= fwd_a;
      src_b_q     <= fwd_b;
      const_q     <= constante;
      alu_src_q   <= bus.alu_src_in;
      reg_write_q <= bus.id_valid && bus.reg_write_in;
      mem_read_q  <= bus.id_valid && bus.mem_read_in;
      rd_q        <= bus.rd_in;
    end
  end
  assign bus.load_use_stall = lus;
  assign bus.ex_valid       = valid_q;
  assign bus.ex_src_a       = src_a_q;
  assign bus.ex_src_b       = src_b_q;
  assign bus.ex_constante   = const_q;
  assign bus.ex_alu_src     = alu_src_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_mem_read    = mem_read_q;
  assign bus.ex_rd          = rd_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vector table plus reset, load-use, stall and flush sequences
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        id_valid;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic        ez, als, rw, mr;
    logic [4:0]  rd;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        ev;
    logic [31:0] ea, eb, ec;
    logic        erw;
  } vec_t;
  vec_t v [6];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t t);
    bus.id_valid = t.id_valid;
    bus.rs_addr = t.rs;
    bus.rt_addr = t.rt;
    bus.rs_data = t.rsd;
    bus.rt_data = t.rtd;
    bus.imm16 = t.imm;
    bus.ext_zero = t.ez;
    bus.alu_src_in = t.als;
    bus.reg_write_in = t.rw;
    bus.mem_read_in = t.mr;
    bus.rd_in = t.rd;
    bus.exmem_reg_write = t.xw;
    bus.exmem_rd = t.xrd;
    bus.exmem_result = t.xres;
    bus.memwb_reg_write = t.ww;
    bus.memwb_rd = t.wrd;
    bus.memwb_result = t.wres;
  endtask
  task automatic chk_zero(input string n);
    chk({n, ".valid"}, {31'b0, bus.ex_valid}, 32'd0);
    chk({n, ".a"}, bus.ex_src_a, 32'd0);
    chk({n, ".b"}, bus.ex_src_b, 32'd0);
    chk({n, ".const"}, bus.ex_constante, 32'd0);
    chk({n, ".ctrl"}, {28'b0, bus.ex_alu_src, bus.ex_reg_write, bus.ex_mem_read, 1'b0}, 32'd0);
    chk({n, ".rd"}, {27'b0, bus.ex_rd}, 32'd0);
  endtask
  initial begin
    v[0] = '{1'b1, 5'd1, 5'd2, 32'd11, 32'd22, 16'hFFF6, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3,
             1'b0, 5'd1, 32'hAA, 1'b0, 5'd2, 32'hBB, 1'b1, 32'd11, 32'd22, 32'hFFFFFFF6, 1'b1};
    v[1] = '{1'b1, 5'd1, 5'd2, 32'd11, 32'd22, 16'hFFF6, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3,
             1'b1, 5'd1, 32'hAA, 1'b1, 5'd2, 32'hBB, 1'b1, 32'hAA, 32'hBB, 32'h0000FFF6, 1'b1};
    v[2] = '{1'b1, 5'd4, 5'd8, 32'd44, 32'd1, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12,
             1'b1, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b1, 32'd44, 32'hAA, 32'h00007FFF, 1'b1};
    v[3] = '{1'b1, 5'd4, 5'd8, 32'd44, 32'd1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12,
             1'b0, 5'd8, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b1, 32'd44, 32'hBB, 32'hFFFF8000, 1'b1};
    v[4] = '{1'b1, 5'd0, 5'd0, 32'd7, 32'd5, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd13,
             1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 1'b1, 32'd7, 32'd5, 32'h00008000, 1'b1};
    v[5] = '{1'b0, 5'd3, 5'd6, 32'd33, 32'd66, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 5'd14,
             1'b0, 5'd0, 32'hAA, 1'b0, 5'd0, 32'hBB, 1'b0, 32'd33, 32'd66, 32'h00001234, 1'b0};
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.id_valid = 1'b1;
    bus.rs_addr = 5'($urandom());
    bus.rt_addr = 5'($urandom());
    bus.rs_data = $urandom();
    bus.rt_data = $urandom();
    bus.imm16 = 16'($urandom());
    bus.ext_zero = 1'($urandom());
    bus.alu_src_in = 1'b1;
    bus.reg_write_in = 1'b1;
    bus.mem_read_in = 1'b1;
    bus.rd_in = 5'($urandom());
    bus.exmem_reg_write = 1'($urandom());
    bus.exmem_rd = 5'($urandom());
    bus.exmem_result = $urandom();
    bus.memwb_reg_write = 1'($urandom());
    bus.memwb_rd = 5'($urandom());
    bus.memwb_result = $urandom();
    step();
    step();
    chk_zero("reset");
    chk("reset.lus", {31'b0, bus.load_use_stall}, 32'd0);
    drive(v[0]);
    rst_n = 1'b1;
    step();
    chk("release.valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("release.a", bus.ex_src_a, 32'd11);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      step();
      chk($sformatf("vec%0d.valid", i), {31'b0, bus.ex_valid}, {31'b0, v[i].ev});
      chk($sformatf("vec%0d.a", i), bus.ex_src_a, v[i].ea);
      chk($sformatf("vec%0d.b", i), bus.ex_src_b, v[i].eb);
      chk($sformatf("vec%0d.const", i), bus.ex_constante, v[i].ec);
      chk($sformatf("vec%0d.alu_src", i), {31'b0, bus.ex_alu_src}, {31'b0, v[i].als});
      chk($sformatf("vec%0d.rw", i), {31'b0, bus.ex_reg_write}, {31'b0, v[i].erw});
      chk($sformatf("vec%0d.mr", i), {31'b0, bus.ex_mem_read}, 32'd0);
      chk($sformatf("vec%0d.rd", i), {27'b0, bus.ex_rd}, {27'b0, v[i].rd});
    end
    drive(v[0]);
    bus.mem_read_in = 1'b1;
    bus.rd_in = 5'd9;
    step();
    chk("lw.mr", {31'b0, bus.ex_mem_read}, 32'd1);
    chk("lw.rd", {27'b0, bus.ex_rd}, 32'd9);
    bus.mem_read_in = 1'b0;
    bus.rd_in = 5'd10;
    bus.rs_addr = 5'd9;
    bus.rs_data = 32'h99;
    bus.memwb_reg_write = 1'b1;
    bus.memwb_rd = 5'd9;
    bus.memwb_result = 32'h1234;
    #1;
    chk("lu.stall", {31'b0, bus.load_use_stall}, 32'd1);
    step();
    chk("lu.bubble", {31'b0, bus.ex_valid}, 32'd0);
    chk("lu.bubble_mr", {31'b0, bus.ex_mem_read}, 32'd0);
    chk("lu.release", {31'b0, bus.load_use_stall}, 32'd0);
    step();
    chk("lu.valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("lu.fwd_a", bus.ex_src_a, 32'h1234);
    chk("lu.rd", {27'b0, bus.ex_rd}, 32'd10);
    drive(v[0]);
    bus.rs_data = 32'h55;
    step();
    bus.stall = 1'b1;
    bus.rs_data = 32'h66;
    bus.imm16 = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.valid", i), {31'b0, bus.ex_valid}, 32'd1);
      chk($sformatf("stall%0d.a", i), bus.ex_src_a, 32'h55);
      chk($sformatf("stall%0d.const", i), bus.ex_constante, 32'hFFFFFFF6);
    end
    bus.flush = 1'b1;
    step();
    chk_zero("flush_stall");
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(v[0]);
    step();
    chk("pre_rst.valid", {31'b0, bus.ex_valid}, 32'd1);
    bus.stall = 1'b1;
    rst_n = 1'b0;
    step();
    chk_zero("mid_stall_rst");
    rst_n = 1'b1;
    bus.stall = 1'b0;
    step();
    chk("post_rst.valid", {31'b0, bus.ex_valid}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage of the MIPS datapath; supplies everything the ALU operand-B mux consumes: register B value, extended constant and ALUScr.
- Also registers operand A.
- Extends the 16-bit immediate and resolves EX/MEM and MEM/WB forwarding before capture.
- Detects load-use hazards and inserts a bubble.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode stage holds a valid instruction
- stall  in  1  external hold (e.g. memory wait)
- flush  in  1  kill instruction entering EX (branch taken)
- rs_addr  in  REG_AW  source A register number
- rt_addr  in  REG_AW  source B register number
- rs_data  in  DATA_W  register file read A
- rt_data  in  DATA_W  register file read B
- imm16  in  16  instruction immediate field
- ext_zero  in  1  1 = zero-extend (andi/ori), 0 = sign-extend
- alu_src_in  in  1  ALUScr from control
- reg_write_in  in  1  instruction writes a register
- mem_read_in  in  1  instruction is a load
- rd_in  in  REG_AW  destination register number
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  REG_AW  EX/MEM destination
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  REG_AW  MEM/WB destination
- memwb_result  in  DATA_W  MEM/WB write-back value
- load_use_stall  out  1  combinational, hold PC and IF/ID
- ex_valid  out  1  EX holds a valid instruction
- ex_src_a  out  DATA_W  forwarded operand A
- ex_src_b  out  DATA_W  forwarded register B (scrB)
- ex_constante  out  DATA_W  extended immediate
- ex_alu_src  out  1  registered ALUScr
- ex_reg_write  out  1  registered reg_write
- ex_mem_read  out  1  registered mem_read
- ex_rd  out  REG_AW  registered destination

Behaviour:
- Reset: rst_n low at a rising edge clears every registered output to 0 (ex_valid=0, all data and control fields 0). Reset mid-stall or mid-hazard discards the held instruction.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == rs_addr | ex_rd == rt_addr). Comparison is against the current registered EX contents.
- Extension:
  - ext_zero=1: constante = {16'b0, imm16}.
  - ext_zero=0: constante = {16{imm16[15]}, imm16}.
- Forwarding, evaluated separately for rs and rt:
  - EX/MEM match (reg_write=1, rd==addr, addr!=0) selects exmem_result.
  - Else MEM/WB match (same conditions) selects memwb_result.
  - Else register file data.
  - EX/MEM has priority when both match. Register 0 is never forwarded; it passes the register file value.
- Per-edge priority, highest first:
  1. rst_n=0: clear.
  2. flush=1: bubble (ex_valid, ex_reg_write, ex_mem_read = 0; data fields cleared to 0). Applies even when stall=1.
  3. stall=1: hold all registers unchanged.
  4. load_use_stall=1: bubble, as for flush.
  5. Otherwise capture: ex_valid=id_valid, forwarded operands, constante, and control fields.
- When id_valid=0, capture gives ex_valid=0 and ex_reg_write=ex_mem_read=0.
- Latency: 1 cycle from ID inputs to ex_* outputs. A hazard delays the instruction exactly 1 cycle; the upstream holds the same instruction, and it is captured on the next edge with MEM/WB forwarding.
- ex_alu_src is passed unchanged, with no interpretation. The downstream mux picks ex_src_b or ex_constante.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs -> every output 0. Release -> first capture appears 1 cycle later.
- Extension: imm16=16'hFFF6, ext_zero=0 -> ex_constante=32'hFFFFFFF6. ext_zero=1 -> 32'h0000FFF6.
- Forwarding priority: rt_addr=8, rt_data=1, exmem (rw=1, rd=8, result=0xAA), memwb (rw=1, rd=8, result=0xBB) -> ex_src_b=0xAA. Clear exmem_reg_write -> 0xBB. rt_addr=0 with both matching rd=0 -> rt_data.
- Load-use: EX holds lw to rd=9 (ex_mem_read=1); ID uses rs=9 -> load_use_stall=1, next cycle ex_valid=0. Following cycle the instruction is captured with ex_src_a = memwb_result when memwb_rd=9.
- Stall vs flush: stall=1 for 3 cycles -> outputs constant. stall=1 with flush=1 -> ex_valid=0 next edge.
- Mid-stall reset: stall=1, ex_valid=1, rst_n=0 for 1 edge -> ex_valid=0 and all fields 0.
